// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit holding the architectural HI/LO registers.
// One radix-2 step per cycle over WIDTH cycles, then a sign-fix cycle; a divide by zero
// short-circuits to a one-cycle completion.
// Optional feature macro: MULDIV_SIGNED_EN -- when defined, op[1] selects signed MULT/DIV;
// when undefined, every operation is unsigned (latency is unchanged).
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StZero} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;          // product / quotient must be negated
  logic             rem_neg_q, rem_neg_d;  // remainder must be negated
  logic [WIDTH-1:0] opnd_q, opnd_d;        // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;    // product upper half / partial remainder
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;    // multiplier+product lower / dividend+quotient
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic is_signed;
`ifdef MULDIV_SIGNED_EN
  assign is_signed = op[1];
`else
  logic unused_op_sign;
  assign unused_op_sign = op[1];
  assign is_signed      = 1'b0;
`endif

  // Operand preparation at the start edge: magnitudes and result sign flags.
  logic             rs_neg, rt_neg, zero_div;
  logic [WIDTH-1:0] abs_rs, abs_rt;

  assign rs_neg   = is_signed & rs_val[WIDTH-1];
  assign rt_neg   = is_signed & rt_val[WIDTH-1];
  assign abs_rs   = rs_neg ? -rs_val : rs_val;
  assign abs_rt   = rt_neg ? -rt_val : rt_val;
  assign zero_div = op[0] & (rt_val == '0);

  // Shift-add multiply step: add multiplicand to upper half, shift whole product right.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);

  // Restoring divide step: shift in next dividend bit, trial-subtract the divisor.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] div_diff;
  logic           div_ok;
  assign rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, opnd_q};
  assign div_ok   = ~div_diff[WIDTH];

  // Sign correction applied in the fix cycle.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  assign prod_fix = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
  assign quo_fix  = neg_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = rem_neg_q ? -acc_hi_q : acc_hi_q;

  // Next-state logic for the controller, datapath and HI/LO registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    opnd_d    = opnd_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          busy_d    = 1'b1;
          dbz_d     = 1'b0;
          cnt_d     = '0;
          is_div_d  = op[0];
          neg_d     = rs_neg ^ rt_neg;
          rem_neg_d = rs_neg;
          opnd_d    = abs_rt;
          acc_hi_d  = '0;
          if (zero_div) begin
            // Keep the raw dividend: it is returned unchanged in HI.
            state_d  = StZero;
            acc_lo_d = rs_val;
          end else begin
            state_d  = StCalc;
            acc_lo_d = abs_rs;
          end
        end else begin
          if (hi_we) hi_d = rs_val;
          if (lo_we) lo_d = rs_val;
        end
      end

      StCalc: begin
        if (is_div_q) begin
          acc_hi_d = div_ok ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ok};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) state_d = StFix;
      end

      StFix: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      StZero: begin
        hi_d    = acc_lo_q;
        lo_d    = '1;
        dbz_d   = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight without a result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      opnd_q    <= opnd_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized checks of mul_div_unit against a plain-arithmetic
// reference model (honours MULDIV_SIGNED_EN the same way the design does).
module tb_mul_div_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_pass  = 0;
  int n_total = 0;

  // Architectural state expected by the model.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_dz = 1'b0;

  always #5 CLK = ~CLK;

  mul_div_unit #(.WIDTH(32)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .op          (op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic.
  function automatic void ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rh, output logic [31:0] rl,
                                 output logic dz);
    logic        sgn;
    longint      sa, sb, q, r, ps;
    logic [63:0] p;
    sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
    sgn = o[1];
`endif
    dz = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    if (o[0]) begin
      if (b == 32'd0) begin
        rh = a;
        rl = 32'hFFFF_FFFF;
        dz = 1'b1;
      end else if (sgn) begin
        q  = sa / sb;
        r  = sa % sb;
        rl = q[31:0];
        rh = r[31:0];
      end else begin
        rl = a / b;
        rh = a % b;
      end
    end else begin
      if (sgn) begin
        ps = sa * sb;
        p  = ps;
      end else begin
        p = {32'd0, a} * {32'd0, b};
      end
      rh = p[63:32];
      rl = p[31:0];
    end
  endfunction

  // One operation: start edge, bounded wait for done, latency/hold/result checks.
  // disturb: extra start pulse at E5 and hi_we/lo_we while busy. chain: leave the bench
  // on the done cycle so the caller can issue a back-to-back start.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit disturb, input bit chain);
    logic [31:0] eh, el;
    logic        edz;
    int          cyc;
    int          exp_lat;
    bit          held;
    ref_op(o, a, b, eh, el, edz);
    exp_lat = (o[0] && b == 32'd0) ? 1 : 33;
    op      = o;
    rs_val  = a;
    rt_val  = b;
    start   = 1'b1;
    tick();
    start  = 1'b0;
    check({tag, " busy_after_E0"}, busy, 1);
    check({tag, " dz_cleared_E0"}, div_by_zero, 0);
    rs_val = $urandom;
    rt_val = $urandom;
    held   = 1'b1;
    cyc    = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (hi !== m_hi || lo !== m_lo || busy !== 1'b1) held = 1'b0;
      start = disturb && (cyc == 4);
      hi_we = disturb && (cyc >= 6) && (cyc <= 8);
      lo_we = disturb && (cyc >= 6) && (cyc <= 8);
      if (start) op = 2'($urandom_range(0, 3));
      tick();
      cyc++;
    end
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " hold_while_busy"}, held, 1);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
    check({tag, " dz"}, div_by_zero, edz);
    check({tag, " busy_at_done"}, busy, 0);
    m_hi = eh;
    m_lo = el;
    m_dz = edz;
    if (!chain) begin
      tick();
      check({tag, " done_one_cycle"}, done, 0);
    end
  endtask

  logic [31:0] div_lo_exp, div_hi_exp;
  int          done_seen;

  initial begin
    // Reset state
    #1 RST = 1'b1;
    tick();
    tick();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset dz", div_by_zero, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    RST = 1'b0;
    tick();

    // MULTU 0xFFFFFFFF * 2
    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
    check("multu_max const hi", hi, 32'h0000_0001);
    check("multu_max const lo", lo, 32'hFFFF_FFFE);

    // DIV -7 / 2
`ifdef MULDIV_SIGNED_EN
    div_lo_exp = 32'hFFFF_FFFD;
    div_hi_exp = 32'hFFFF_FFFF;
`else
    div_lo_exp = 32'h7FFF_FFFC;
    div_hi_exp = 32'h0000_0001;
`endif
    run_op("div_neg7", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
    check("div_neg7 const lo", lo, div_lo_exp);
    check("div_neg7 const hi", hi, div_hi_exp);

    // Signed overflow corner and signed multiply
    run_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("mult_neg", 2'b10, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b0);

    // DIVU by zero, then div_by_zero must survive an MTHI
    run_op("divu_zero", 2'b01, 32'h0000_0064, 32'h0000_0000, 1'b0, 1'b0);
    check("divu_zero const hi", hi, 32'h0000_0064);
    check("divu_zero const lo", lo, 32'hFFFF_FFFF);
    rs_val = 32'hCAFE_0000;
    hi_we  = 1'b1;
    tick();
    hi_we = 1'b0;
    m_hi  = 32'hCAFE_0000;
    check("mthi hi", hi, m_hi);
    check("mthi lo_unchanged", lo, m_lo);
    check("dz_holds", div_by_zero, 1);

    // Ignored start and writes while busy, operand change mid-run, then back-to-back start
    run_op("multu_disturb", 2'b00, 32'h1234_5678, 32'h9ABC_DEF1, 1'b1, 1'b1);
    run_op("b2b", 2'b01, 32'hFFFF_0000, 32'h0000_0123, 1'b0, 1'b0);

    // MTLO while idle, then MTHI+MTLO together
    rs_val = 32'hDEAD_BEEF;
    lo_we  = 1'b1;
    tick();
    lo_we = 1'b0;
    m_lo  = 32'hDEAD_BEEF;
    check("mtlo lo", lo, m_lo);
    check("mtlo hi_unchanged", hi, m_hi);
    rs_val = 32'h1357_9BDF;
    hi_we  = 1'b1;
    lo_we  = 1'b1;
    tick();
    hi_we = 1'b0;
    lo_we = 1'b0;
    m_hi  = 32'h1357_9BDF;
    m_lo  = 32'h1357_9BDF;
    check("mthilo hi", hi, m_hi);
    check("mthilo lo", lo, m_lo);

    // Randomized operations, with occasional zero/edge divisors and back-to-back starts
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      int          sel;
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) rb = 32'hFFFF_FFFF;
      else if (sel == 2) rb = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run_op("rand", ro, ra, rb, 1'b0, bit'($urandom_range(0, 3) == 0));
    end
    tick();

    // Reset in the middle of a MULTU
    op     = 2'b00;
    rs_val = 32'hFFFF_FFFF;
    rt_val = 32'hFFFF_FFFF;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    RST = 1'b1;
    #1;
    check("rst_mid busy", busy, 0);
    check("rst_mid done", done, 0);
    check("rst_mid hi", hi, 0);
    check("rst_mid lo", lo, 0);
    check("rst_mid dz", div_by_zero, 0);
    #2 RST = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    check("rst_mid no_done", done_seen, 0);
    check("rst_mid hi_after", hi, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
